bambu_mem_port_initiator: RTL and testbench
===========================================

Name: bambu_mem_port_initiator

Overview:
- Synthesizable single-lane master for the Bambu minimal-memory interface: Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram and Mout_data_ram_size out; M_Rdata_ram and M_DataRdy back.
- Takes one read or write request at a time over a valid/ready port and drives the bus until the responder asserts M_DataRdy.
- Returns the read data, or an error, over a valid/ready response port.
- Used by bring-up DMA/preload logic to fill and check external memory seen by HLS-generated accelerators, without relying on the simulation-only memory model.

Parameters:
- ADDR_W, 9, bus address width per lane.
- DATA_W, 32, bus data width per lane.
- SIZE_W, 6, width of data_ram_size (access size in bits).
- TIMEOUT, 255, maximum cycles to wait for M_DataRdy before aborting; must be ≥1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid&&req_ready at a rising edge.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data, LSB-aligned.
- req_size  in  SIZE_W  access size in bits (8/16/32 legal).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data, masked to size; 0 for writes and errors.
- rsp_err  out  1  1 = timeout or illegal size.
- Mout_oe_ram  out  1  read enable.
- Mout_we_ram  out  1  write enable.
- Mout_addr_ram  out  ADDR_W  address.
- Mout_Wdata_ram  out  DATA_W  write data.
- Mout_data_ram_size  out  SIZE_W  access size.
- M_Rdata_ram  in  DATA_W  read data, valid in the cycle M_DataRdy=1.
- M_DataRdy  in  1  access complete.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, wait counter 0.
  - All outputs 0 except req_ready=1.
  - An in-flight access is dropped: bus enables fall immediately and no response is produced.
- All bus outputs are registered. Mout_oe_ram and Mout_we_ram are never both 1.
- Addr, Wdata and size are held stable for the whole access. Wdata is req_wdata & mask.
- mask = (1<<size)-1; mask is all ones when size==DATA_W.
- IDLE: req_ready=1.
  - On accept with size in {8,16,32} and size ≤ DATA_W: latch the request, assert oe (read) or we (write) from the same edge, clear the counter, go to ACCESS.
  - On accept with an illegal size: no bus activity; rsp_err=1, rsp_rdata=0; go to RESP.
- ACCESS: req_ready=0; counter increments each cycle.
  - At an edge where M_DataRdy=1: deassert oe/we at that edge; for reads, capture M_Rdata_ram & mask into rsp_rdata; rsp_err=0; go to RESP.
  - At an edge where M_DataRdy=0 and the counter has reached TIMEOUT-1: deassert oe/we, rsp_err=1, rsp_rdata=0, go to RESP.
  - If M_DataRdy=1 and the timeout both occur at the same edge, M_DataRdy wins (success).
- RESP: rsp_valid=1, bus idle, req_ready=0.
  - Response data is stable until rsp_ready=1 at an edge; then rsp_valid=0 and state returns to IDLE.
  - rsp_ready held low stalls indefinitely.
- Latency against a responder with read delay 2 and write delay 1:
  - Read: oe is high for exactly 2 cycles; rsp_valid rises 2 edges after acceptance.
  - Write: we is high for 1 cycle; rsp_valid rises 1 edge after acceptance.
- Throughput: at least one bus-idle cycle between accesses (through RESP/IDLE), so the responder's ready counters see oe/we low.
- M_DataRdy seen outside ACCESS is ignored.
- Counter width is clog2(TIMEOUT+1); it never wraps because it is cleared on entry to ACCESS.

Test Plan:
- Read: after reset, pair with a 2-cycle-read responder holding 0xDEADBEEF at 0x010; request read at 0x010, size 32 -> oe high exactly 2 cycles, we stays 0, rsp_valid 2 edges after acceptance, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Write then read: write 0x000000A5 at 0x020, size 8 -> we high 1 cycle, Wdata=0x000000A5, size=8, rsp_err=0; then read 0x020, size 8 (memory byte 0x20=0xA5, next bytes 0x11) -> rsp_rdata=0x000000A5.
- Timeout: responder never raises M_DataRdy, TIMEOUT=4 -> oe high exactly 4 cycles, then rsp_valid with rsp_err=1, rsp_rdata=0, bus idle afterwards.
- Illegal size and backpressure: request size 12 -> no oe/we ever, rsp_err=1; hold rsp_ready=0 for 10 cycles -> rsp_valid and data stable, req_ready=0, busy=1; release -> IDLE next edge.
- Reset mid-access: drop reset in the 2nd oe cycle -> oe, busy, rsp_valid 0 immediately (before next edge), req_ready=1; no response emitted after reset release; next read completes normally.
- Random soak: 1000 random reads/writes, sizes 8/16/32, random rsp_ready against the reference memory model -> data matches the scoreboard, never oe&&we, no back-to-back enable without an idle cycle.

Source files
------------

// File: rtl/bambu_mem_port_initiator.sv
// bambu_mem_port_initiator: single-lane master for the Bambu minimal-memory bus.
// Accepts one request at a time, runs the bus until M_DataRdy or timeout, then returns a response.
module bambu_mem_port_initiator #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int SIZE_W  = 6,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [SIZE_W-1:0] req_size,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              Mout_oe_ram,
  output logic              Mout_we_ram,
  output logic [ADDR_W-1:0] Mout_addr_ram,
  output logic [DATA_W-1:0] Mout_Wdata_ram,
  output logic [SIZE_W-1:0] Mout_data_ram_size,
  input  logic [DATA_W-1:0] M_Rdata_ram,
  input  logic              M_DataRdy,
  output logic              busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic oe_q, oe_d, we_q, we_d, err_q, err_d, legal, tout;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SIZE_W-1:0] size_q, size_d;
  function automatic logic [DATA_W-1:0] mask_of(input logic [SIZE_W-1:0] s);
    return (int'(s) >= DATA_W) ? '1 : (DATA_W'(1) << s) - DATA_W'(1);
  endfunction
  assign legal = (int'(req_size) == 8 || int'(req_size) == 16 || int'(req_size) == 32)
                 && int'(req_size) <= DATA_W;
  assign tout  = cnt_q == CW'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    oe_d    = oe_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        rdata_d = '0;
        err_d   = !legal;
        state_d = legal ? ACCESS : RESP;
        if (legal) begin
          addr_d  = req_addr;
          wdata_d = req_wdata & mask_of(req_size);
          size_d  = req_size;
          oe_d    = !req_we;
          we_d    = req_we;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        // a late M_DataRdy on the timeout edge still counts as success
        if (M_DataRdy || tout) begin
          oe_d    = 1'b0;
          we_d    = 1'b0;
          err_d   = !M_DataRdy;
          rdata_d = (M_DataRdy && oe_q) ? M_Rdata_ram & mask_of(size_q) : '0;
          state_d = RESP;
        end
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  assign req_ready          = state_q == IDLE;
  assign rsp_valid          = state_q == RESP;
  assign busy               = state_q != IDLE;
  assign rsp_rdata          = rdata_q;
  assign rsp_err            = err_q;
  assign Mout_oe_ram        = oe_q;
  assign Mout_we_ram        = we_q;
  assign Mout_addr_ram      = addr_q;
  assign Mout_Wdata_ram     = wdata_q;
  assign Mout_data_ram_size = size_q;
endmodule

// File: tb/tb_bambu_mem_port_initiator.sv
// tb_bambu_mem_port_initiator: directed vectors, corner sequences and a random soak
// against a byte-addressed responder (read delay 2, write delay 1) and a scoreboard memory.
module tb_bambu_mem_port_initiator;
  logic clock, reset, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic oe, we, M_DataRdy, busy;
  logic [8:0] req_addr, maddr;
  logic [31:0] req_wdata, rsp_rdata, mwdata, M_Rdata_ram;
  logic [5:0] req_size, msize;
  bambu_mem_port_initiator #(.ADDR_W(9), .DATA_W(32), .SIZE_W(6), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(maddr), .Mout_Wdata_ram(mwdata),
    .Mout_data_ram_size(msize), .M_Rdata_ram(M_Rdata_ram), .M_DataRdy(M_DataRdy), .busy(busy)
  );
  initial clock = 0;
  always #5 clock = ~clock;
  int total = 0, bad = 0;
  logic [7:0] mem [512];
  logic [7:0] sb [512];
  int rc = 0;
  logic dead = 0, load = 1;
  assign M_DataRdy = !dead && ((oe && rc == 1) || (we && rc == 0));
  assign M_Rdata_ram = {mem[(int'(maddr)+3)%512], mem[(int'(maddr)+2)%512],
                        mem[(int'(maddr)+1)%512], mem[int'(maddr)]};
  always @(posedge clock) begin
    if (load) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h11;
      mem[16'h10] <= 8'hEF; mem[16'h11] <= 8'hBE; mem[16'h12] <= 8'hAD; mem[16'h13] <= 8'hDE;
    end else begin
      rc <= ((oe || we) && !M_DataRdy) ? rc + 1 : 0;
      if (we && M_DataRdy)
        for (int i = 0; i < int'(msize) / 8; i++) mem[(int'(maddr)+i)%512] <= mwdata[8*i+:8];
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clock) if (reset) begin
    total++;
    if (oe && we) begin
      bad++;
      $display("FAIL oe_we_exclusive: got oe=%b we=%b expected not both", oe, we);
    end
  end
  function automatic logic [31:0] sb_rd(input logic [8:0] a, input logic [5:0] s);
    logic [31:0] v;
    v = {sb[(int'(a)+3)%512], sb[(int'(a)+2)%512], sb[(int'(a)+1)%512], sb[int'(a)]};
    return s == 32 ? v : v & ((32'd1 << s) - 32'd1);
  endfunction
  logic [31:0] rd, wd_seen;
  logic er;
  logic [5:0] sz_seen;
  int lat, en;
  task automatic run_req(input logic w, input logic [8:0] a, input logic [31:0] d,
                         input logic [5:0] s, input int hold);
    @(negedge clock);
    chk("idle_bus", {30'b0, oe, we}, 0);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_we = w; req_addr = a; req_wdata = d; req_size = s;
    @(posedge clock);
    #1 req_valid = 0;
    lat = 0; en = 0; wd_seen = 0; sz_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (oe || we) begin
        en++; wd_seen = mwdata; sz_seen = msize;
      end
      if (rsp_valid) break;
      @(posedge clock);
      lat++;
    end
    chk("rsp_seen", rsp_valid, 1);
    rd = rsp_rdata; er = rsp_err;
    repeat (hold) @(negedge clock);
    rsp_ready = 1;
    @(posedge clock);
    #1 rsp_ready = 0;
    @(negedge clock);
    chk("rsp_drop", rsp_valid, 0);
    chk("back_idle", req_ready, 1);
    if (w && (s == 8 || s == 16 || s == 32) && !dead)
      for (int i = 0; i < int'(s) / 8; i++) sb[(int'(a)+i)%512] = d[8*i+:8];
  endtask
  typedef struct {
    logic w; logic [8:0] a; logic [31:0] d; logic [5:0] s;
    logic [31:0] erd; logic eer; int elat; int een; logic [31:0] ewd;
  } vec_t;
  vec_t v[11];
  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_size = 0; rsp_ready = 0;
    for (int i = 0; i < 512; i++) sb[i] = 8'h11;
    sb[16'h10] = 8'hEF; sb[16'h11] = 8'hBE; sb[16'h12] = 8'hAD; sb[16'h13] = 8'hDE;
    repeat (2) @(posedge clock);
    @(negedge clock);
    load = 0;
    chk("reset_ctrl", {26'b0, req_ready, rsp_valid, busy, oe, we, rsp_err}, 32'b100000);
    chk("reset_data", rsp_rdata | mwdata | {23'b0, maddr} | {26'b0, msize}, 0);
    reset = 1;
    v[0]  = '{0, 9'h010, 32'h0,        6'd32, 32'hDEADBEEF, 0, 2, 2, 0};
    v[1]  = '{1, 9'h020, 32'h000000A5, 6'd8,  32'h0,        0, 1, 1, 32'h000000A5};
    v[2]  = '{0, 9'h020, 32'h0,        6'd8,  32'h000000A5, 0, 2, 2, 0};
    v[3]  = '{0, 9'h020, 32'h0,        6'd16, 32'h000011A5, 0, 2, 2, 0};
    v[4]  = '{1, 9'h040, 32'h12345678, 6'd16, 32'h0,        0, 1, 1, 32'h00005678};
    v[5]  = '{0, 9'h040, 32'h0,        6'd32, 32'h11115678, 0, 2, 2, 0};
    v[6]  = '{1, 9'h060, 32'hCAFEF00D, 6'd32, 32'h0,        0, 1, 1, 32'hCAFEF00D};
    v[7]  = '{0, 9'h060, 32'h0,        6'd32, 32'hCAFEF00D, 0, 2, 2, 0};
    v[8]  = '{0, 9'h07F, 32'h0,        6'd12, 32'h0,        1, 0, 0, 0};
    v[9]  = '{1, 9'h080, 32'hFFFFFFFF, 6'd0,  32'h0,        1, 0, 0, 0};
    v[10] = '{0, 9'h1FE, 32'h0,        6'd32, 32'h11111111, 0, 2, 2, 0};
    for (int i = 0; i < 11; i++) begin
      run_req(v[i].w, v[i].a, v[i].d, v[i].s, i % 3);
      chk($sformatf("v%0d_rdata", i), rd, v[i].erd);
      chk($sformatf("v%0d_err", i), er, v[i].eer);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v[i].elat));
      chk($sformatf("v%0d_enable_cycles", i), 32'(en), 32'(v[i].een));
      if (v[i].een > 0) chk($sformatf("v%0d_size", i), sz_seen, v[i].s);
      if (v[i].w && v[i].een > 0) chk($sformatf("v%0d_wdata", i), wd_seen, v[i].ewd);
    end
    dead = 1;
    run_req(0, 9'h010, 0, 6'd32, 0);
    chk("tmo_err", er, 1);
    chk("tmo_rdata", rd, 0);
    chk("tmo_latency", 32'(lat), 4);
    chk("tmo_oe_cycles", 32'(en), 4);
    chk("tmo_bus_idle", {30'b0, oe, we}, 0);
    dead = 0;
    @(negedge clock);
    req_valid = 1; req_we = 0; req_addr = 9'h030; req_size = 6'd12;
    @(posedge clock);
    #1 req_valid = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk("bp_ctrl", {26'b0, rsp_valid, rsp_err, req_ready, busy, oe, we}, 32'b110100);
      chk("bp_rdata", rsp_rdata, 0);
    end
    rsp_ready = 1;
    @(posedge clock);
    #1 rsp_ready = 0;
    @(negedge clock);
    chk("bp_release", {29'b0, busy, req_ready, rsp_valid}, 32'b010);
    @(negedge clock);
    req_valid = 1; req_we = 0; req_addr = 9'h010; req_size = 6'd32;
    @(posedge clock);
    #1 req_valid = 0;
    @(negedge clock);
    chk("rst_oe_cycle1", oe, 1);
    @(negedge clock);
    chk("rst_oe_cycle2", oe, 1);
    reset = 0;
    #1 chk("rst_async", {28'b0, oe, busy, rsp_valid, req_ready}, 32'b0001);
    @(negedge clock);
    reset = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk("rst_no_rsp", {30'b0, rsp_valid, oe}, 0);
    end
    run_req(0, 9'h010, 0, 6'd32, 0);
    chk("rst_after_rdata", rd, 32'hDEADBEEF);
    chk("rst_after_err", er, 0);
    for (int n = 0; n < 1000; n++) begin
      logic w;
      logic [8:0] a;
      logic [31:0] d;
      logic [5:0] s;
      int sel;
      w = 1'($urandom_range(0, 1));
      a = 9'($urandom_range(0, 511));
      d = $urandom;
      sel = $urandom_range(0, 2);
      s = sel == 0 ? 6'd8 : sel == 1 ? 6'd16 : 6'd32;
      if (!w) begin
        logic [31:0] exp;
        exp = sb_rd(a, s);
        run_req(0, a, d, s, $urandom_range(0, 3));
        chk("soak_rdata", rd, exp);
      end else run_req(1, a, d, s, $urandom_range(0, 3));
      chk("soak_err", er, 0);
      chk("soak_en_cycles", 32'(en), w ? 1 : 2);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
